// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared states, opcode classes and control-vector bit positions for sequencer_fsm
package seq_pkg;

    localparam int CTRL_W = 30;

    typedef enum logic [3:0] {
        IDLE, FETCH, INCPC, DECODE, EXEC,
        G1, G2, G3, G4, G5, G6,
        HALT, WAIT
    } seqState_e;

    typedef enum logic [2:0] {
        OP_MOV, OP_SETAB, OP_ALU, OP_LOAD, OP_STORE, OP_HALT, OP_GOTO, OP_ILLEGAL
    } opClass_e;

    // Register order A,B,C,D,M1,M2,X,Y must stay contiguous: the FSM indexes it with +: slices.
    localparam int LD_A    = 0;
    localparam int LD_B    = 1;
    localparam int LD_C    = 2;
    localparam int LD_D    = 3;
    localparam int LD_M1   = 4;
    localparam int LD_M2   = 5;
    localparam int LD_X    = 6;
    localparam int LD_Y    = 7;
    localparam int LD_J1   = 8;
    localparam int LD_J2   = 9;
    localparam int LD_INST = 10;
    localparam int LD_PC   = 11;
    localparam int LD_INC  = 12;
    localparam int LD_XY   = 13;

    localparam int SEL_A   = 14;
    localparam int SEL_B   = 15;
    localparam int SEL_C   = 16;
    localparam int SEL_D   = 17;
    localparam int SEL_M1  = 18;
    localparam int SEL_M2  = 19;
    localparam int SEL_X   = 20;
    localparam int SEL_Y   = 21;
    localparam int SEL_PC  = 22;
    localparam int SEL_INC = 23;
    localparam int SEL_M   = 24;
    localparam int SEL_XY  = 25;
    localparam int SEL_J   = 26;

    localparam int MEM_READ  = 27;
    localparam int MEM_WRITE = 28;
    localparam int IMM_OE    = 29;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational opcode classification and field extraction of the Inst register
module seq_decode (
    input  logic [7:0] inst,
    output logic [2:0] opClass,
    output logic [2:0] dst,
    output logic [2:0] src,
    output logic       rBit,
    output logic [2:0] fff,
    output logic [1:0] rr,
    output logic       condD,
    output logic       condS,
    output logic       condC,
    output logic       condZ,
    output logic       condN
);
    import seq_pkg::*;

    opClass_e cls;

    always_comb begin
        cls = OP_ILLEGAL;
        casez (inst)
            8'b00??????: cls = OP_MOV;
            8'b01??????: cls = OP_SETAB;
            8'b11??????: cls = OP_GOTO;
            8'b1000????: cls = OP_ALU;
            8'b100100??: cls = OP_LOAD;
            8'b100110??: cls = OP_STORE;
            8'b10101110: cls = OP_HALT;
            default:     cls = OP_ILLEGAL;
        endcase
    end

    assign opClass = cls;
    assign dst     = inst[5:3];
    assign src     = inst[2:0];
    // SETAB carries its target bit at [5], ALU at [3]
    assign rBit    = (inst[7:6] == 2'b01) ? inst[5] : inst[3];
    assign fff     = inst[2:0];
    assign rr      = inst[1:0];
    assign condD   = inst[5];
    assign condS   = inst[4];
    assign condC   = inst[3];
    assign condZ   = inst[2];
    assign condN   = inst[1];

endmodule

// File: rtl/sequencer_fsm.sv
// rtl/sequencer_fsm.sv - fetch/decode/execute controller for the relay-computer datapath
// Optional single-step mode (step port, WAIT state) under SEQ_SINGLE_STEP_EN.
module sequencer_fsm #(
    parameter int CTRL_W         = seq_pkg::CTRL_W,
    parameter bit START_ON_RESET = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step,
`endif
    input  logic [7:0]        inst,
    input  logic              zero,
    input  logic              carry,
    input  logic              sign,
    output logic [CTRL_W-1:0] ctrl,
    output logic [2:0]        alu_fn,
    output logic [7:0]        imm_data,
    output logic              halted,
    output logic              illegal
);
    import seq_pkg::*;

    seqState_e state, stateNext;
    logic [2:0] opClass;
    logic [2:0] dst, src, fff;
    logic [1:0] rr;
    logic       rBit, condD, condS, condC, condZ, condN;
    logic       taken, takenQ;
    logic       illegalQ;

    seq_decode uDecode (
        .inst    (inst),
        .opClass (opClass),
        .dst     (dst),
        .src     (src),
        .rBit    (rBit),
        .fff     (fff),
        .rr      (rr),
        .condD   (condD),
        .condS   (condS),
        .condC   (condC),
        .condZ   (condZ),
        .condN   (condN)
    );

`ifdef SEQ_SINGLE_STEP_EN
    logic stepQ, stepRise;
    always_ff @(posedge clk) begin
        if (reset) stepQ <= 1'b0;
        else       stepQ <= step;
    end
    assign stepRise = step & ~stepQ;
    localparam seqState_e END_STATE = WAIT;
`else
    localparam seqState_e END_STATE = FETCH;
`endif

    // No condition bits means unconditional
    assign taken = ({condS, condC, condZ, condN} == 4'b0000)
                 | (condS & sign) | (condC & carry) | (condZ & zero) | (condN & ~zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            takenQ   <= 1'b0;
            illegalQ <= 1'b0;
        end else begin
            state <= stateNext;
            if (state == G5)
                takenQ <= taken;
            if (state == DECODE && opClass == OP_ILLEGAL)
                illegalQ <= 1'b1;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:   if (run || START_ON_RESET) stateNext = FETCH;
            FETCH:  stateNext = INCPC;
            INCPC:  stateNext = DECODE;
            DECODE: begin
                case (opClass)
                    OP_GOTO:    stateNext = G1;
                    OP_HALT:    stateNext = HALT;
                    OP_ILLEGAL: stateNext = HALT;
                    default:    stateNext = EXEC;
                endcase
            end
            EXEC:   stateNext = END_STATE;
            G1:     stateNext = G2;
            G2:     stateNext = G3;
            G3:     stateNext = G4;
            G4:     stateNext = G5;
            G5:     stateNext = G6;
            G6:     stateNext = END_STATE;
            HALT:   stateNext = HALT;
`ifdef SEQ_SINGLE_STEP_EN
            WAIT:   if (stepRise) stateNext = FETCH;
`endif
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        alu_fn   = 3'd0;
        imm_data = 8'd0;
        case (state)
            FETCH: begin
                ctrl[SEL_PC]   = 1'b1;
                ctrl[MEM_READ] = 1'b1;
                ctrl[LD_INST]  = 1'b1;
                ctrl[LD_INC]   = 1'b1;
            end
            INCPC, G2, G4: begin
                ctrl[SEL_INC] = 1'b1;
                ctrl[LD_PC]   = 1'b1;
            end
            EXEC: begin
                case (opClass)
                    OP_MOV: begin
                        // ddd == sss is the architectural NOP
                        if (dst != src) begin
                            ctrl[LD_A  +: 8] = 8'b1 << dst;
                            ctrl[SEL_A +: 8] = 8'b1 << src;
                        end
                    end
                    OP_SETAB: begin
                        ctrl[IMM_OE] = 1'b1;
                        imm_data     = {{3{inst[4]}}, inst[4:0]};
                        if (rBit) ctrl[LD_B] = 1'b1;
                        else      ctrl[LD_A] = 1'b1;
                    end
                    OP_ALU: begin
                        alu_fn = fff;
                        if (rBit) ctrl[LD_D] = 1'b1;
                        else      ctrl[LD_A] = 1'b1;
                    end
                    OP_LOAD: begin
                        ctrl[SEL_M]     = 1'b1;
                        ctrl[MEM_READ]  = 1'b1;
                        ctrl[LD_A +: 4] = 4'b1 << rr;
                    end
                    OP_STORE: begin
                        ctrl[SEL_M]      = 1'b1;
                        ctrl[SEL_A +: 4] = 4'b1 << rr;
                        ctrl[MEM_WRITE]  = 1'b1;
                    end
                    default: ;
                endcase
            end
            G1, G3: begin
                ctrl[SEL_PC]   = 1'b1;
                ctrl[MEM_READ] = 1'b1;
                ctrl[LD_INC]   = 1'b1;
                if (state == G1) ctrl[LD_J1] = 1'b1;
                else             ctrl[LD_J2] = 1'b1;
            end
            G5: begin
                if (taken && condD) begin
                    ctrl[SEL_INC] = 1'b1;
                    ctrl[LD_XY]   = 1'b1;
                end
            end
            G6: begin
                if (takenQ) begin
                    ctrl[SEL_J] = 1'b1;
                    ctrl[LD_PC] = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign halted  = (state == HALT);
    assign illegal = illegalQ;

endmodule

// File: tb/tb_sequencer_fsm.sv
// tb/tb_sequencer_fsm.sv - scoreboard bench for sequencer_fsm with a per-cycle expected-strobe model
module tb_sequencer_fsm;
    import seq_pkg::*;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [2:0]        fn;
        logic [7:0]        imm;
        logic              halted;
        logic              illegal;
    } exp_t;

    localparam int LDI  [8] = '{LD_A, LD_B, LD_C, LD_D, LD_M1, LD_M2, LD_X, LD_Y};
    localparam int SELI [8] = '{SEL_A, SEL_B, SEL_C, SEL_D, SEL_M1, SEL_M2, SEL_X, SEL_Y};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic run = 1'b0;
    logic zero = 1'b0, carry = 1'b0, sign = 1'b0;
    logic [7:0] inst = 8'h00;
    logic [CTRL_W-1:0] ctrl;
    logic [2:0] aluFn;
    logic [7:0] immData;
    logic halted, illegal;
`ifdef SEQ_SINGLE_STEP_EN
    logic step = 1'b0;
`endif

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    bit endReq = 1'b0;
    logic expIllegal = 1'b0;

    always #5 clk = ~clk;

    sequencer_fsm dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
`ifdef SEQ_SINGLE_STEP_EN
        .step     (step),
`endif
        .inst     (inst),
        .zero     (zero),
        .carry    (carry),
        .sign     (sign),
        .ctrl     (ctrl),
        .alu_fn   (aluFn),
        .imm_data (immData),
        .halted   (halted),
        .illegal  (illegal)
    );

    function automatic logic [CTRL_W-1:0] b(input int i);
        logic [CTRL_W-1:0] v;
        v = '0;
        v[i[4:0]] = 1'b1;
        return v;
    endfunction

    task automatic push(input logic [CTRL_W-1:0] c, input logic [2:0] f, input logic [7:0] im, input logic h);
        exp_t e;
        e.ctrl = c; e.fn = f; e.imm = im; e.halted = h; e.illegal = expIllegal;
        sb.push_back(e);
    endtask

    task automatic waitCyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) push('0, 3'd0, 8'd0, 1'b0);
        waitCyc(n);
    endtask

    task automatic expectFetch();
        push(b(SEL_PC) | b(MEM_READ) | b(LD_INST) | b(LD_INC), 3'd0, 8'd0, 1'b0);
        push(b(SEL_INC) | b(LD_PC), 3'd0, 8'd0, 1'b0);
        push('0, 3'd0, 8'd0, 1'b0);
    endtask

    task automatic startRun();
        run = 1'b1;
        idleCycles(1);
    endtask

    // Called in the FETCH cycle; leaves the bench in the next FETCH cycle.
    task automatic doInst(input logic [7:0] op, input logic z, input logic c, input logic s);
        int len;
        logic tk;
        inst = op; zero = z; carry = c; sign = s;
        expectFetch();
        len = 4;
        casez (op)
            8'b00??????: push((op[5:3] == op[2:0]) ? '0 : (b(LDI[op[5:3]]) | b(SELI[op[2:0]])), 3'd0, 8'd0, 1'b0);
            8'b01??????: push(b(IMM_OE) | b(op[5] ? LD_B : LD_A), 3'd0, {{3{op[4]}}, op[4:0]}, 1'b0);
            8'b1000????: push(b(op[3] ? LD_D : LD_A), op[2:0], 8'd0, 1'b0);
            8'b100100??: push(b(SEL_M) | b(MEM_READ) | b(LDI[op[1:0]]), 3'd0, 8'd0, 1'b0);
            8'b100110??: push(b(SEL_M) | b(SELI[op[1:0]]) | b(MEM_WRITE), 3'd0, 8'd0, 1'b0);
            default: begin
                tk = (op[4:1] == 4'b0000) | (op[4] & s) | (op[3] & c) | (op[2] & z) | (op[1] & ~z);
                push(b(SEL_PC) | b(MEM_READ) | b(LD_J1) | b(LD_INC), 3'd0, 8'd0, 1'b0);
                push(b(SEL_INC) | b(LD_PC), 3'd0, 8'd0, 1'b0);
                push(b(SEL_PC) | b(MEM_READ) | b(LD_J2) | b(LD_INC), 3'd0, 8'd0, 1'b0);
                push(b(SEL_INC) | b(LD_PC), 3'd0, 8'd0, 1'b0);
                push((tk && op[5]) ? (b(SEL_INC) | b(LD_XY)) : '0, 3'd0, 8'd0, 1'b0);
                push(tk ? (b(SEL_J) | b(LD_PC)) : '0, 3'd0, 8'd0, 1'b0);
                len = 9;
            end
        endcase
        waitCyc(len);
`ifdef SEQ_SINGLE_STEP_EN
        push('0, 3'd0, 8'd0, 1'b0);
        step = 1'b1;
        waitCyc(1);
        step = 1'b0;
`endif
    endtask

    task automatic haltTest(input logic [7:0] op, input logic isIllegal);
        inst = op;
        expectFetch();
        waitCyc(3);
        if (isIllegal) expIllegal = 1'b1;
        for (int i = 0; i < 20; i++) push('0, 3'd0, 8'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            run = 1'($urandom);
            waitCyc(1);
        end
        push('0, 3'd0, 8'd0, 1'b1);
        reset = 1'b1;
        waitCyc(1);
        expIllegal = 1'b0;
        idleCycles(1);
        reset = 1'b0;
        run = 1'b0;
    endtask

    task automatic abortG3(input logic [7:0] op);
        inst = op;
        zero = 1'($urandom); carry = 1'($urandom); sign = 1'($urandom);
        expectFetch();
        push(b(SEL_PC) | b(MEM_READ) | b(LD_J1) | b(LD_INC), 3'd0, 8'd0, 1'b0);
        push(b(SEL_INC) | b(LD_PC), 3'd0, 8'd0, 1'b0);
        waitCyc(5);
        push(b(SEL_PC) | b(MEM_READ) | b(LD_J2) | b(LD_INC), 3'd0, 8'd0, 1'b0);
        reset = 1'b1;
        waitCyc(1);
        idleCycles(2);
        reset = 1'b0;
        run = 1'b0;
        idleCycles(2);
    endtask

    function automatic logic [7:0] randOp();
        case ($urandom_range(0, 5))
            0: return {2'b00, 6'($urandom)};
            1: return {2'b01, 6'($urandom)};
            2: return {4'b1000, 4'($urandom)};
            3: return {6'b100100, 2'($urandom)};
            4: return {6'b100110, 2'($urandom)};
            default: return {2'b11, 6'($urandom)};
        endcase
    endfunction

    initial begin
        @(posedge clk);
        #1;
        idleCycles(2);
        reset = 1'b0;
        idleCycles(2);
        startRun();
        doInst(8'h0A, 1'b0, 1'b0, 1'b0);
        doInst(8'h5F, 1'b0, 1'b0, 1'b0);
        doInst(8'h09, 1'b0, 1'b0, 1'b0);
        doInst(8'hF0, 1'b0, 1'b0, 1'b0);
        doInst(8'hF0, 1'b0, 1'b0, 1'b1);
        doInst(8'hC2, 1'b0, 1'b0, 1'b0);
        doInst(8'hC2, 1'b1, 1'b0, 1'b0);
        doInst(8'h8D, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            run = 1'($urandom);
            doInst(randOp(), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        abortG3(8'hFF);
        startRun();
        for (int i = 0; i < 5; i++) doInst(randOp(), 1'($urandom), 1'($urandom), 1'($urandom));
        haltTest(8'hAE, 1'b0);
        startRun();
        doInst(randOp(), 1'($urandom), 1'($urandom), 1'($urandom));
        haltTest(8'hA0, 1'b1);
        idleCycles(3);
        endReq = 1'b1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if ({ctrl, aluFn, immData, halted, illegal} !== e) begin
                failures++;
                $display("FAIL cycle t=%0t ctrl got %h want %h alu_fn got %0d want %0d imm got %h want %h halted got %b want %b illegal got %b want %b",
                         $time, ctrl, e.ctrl, aluFn, e.fn, immData, e.imm, halted, e.halted, illegal, e.illegal);
            end
        end else if (endReq) begin
            checks++;
            if (ctrl !== '0 || halted !== 1'b0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL final_idle ctrl got %h want 0 halted got %b want 0 illegal got %b want 0", ctrl, halted, illegal);
            end
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1);
    end

endmodule
